power_ctrl: RTL



---
 rtl/power_ctrl_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/power_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/power_ctrl_pkg.sv
// Shared types and default timing constants for the vehicle power controller.
package power_ctrl_pkg;

   typedef enum logic [1:0] {
      OFF          = 2'b00,
      ARMING       = 2'b01,
      ON           = 2'b10,
      RELEASE_WAIT = 2'b11
   } pstate_t;

   // Defaults assume a 100 MHz sys_clk: 10 ms debounce, 1 s hold, 10 s idle.
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_HOLD_CYCLES     = 100_000_000;
   localparam int DEF_IDLE_CYCLES     = 1_000_000_000;

   // Counter width able to hold 0..cycles-1, never narrower than one bit.
   function automatic int cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer for one
// asynchronous push button.
module btn_debounce
   import power_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Any sample that agrees with the current level restarts the stability count.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync2 == level) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt   <= '0;
         level <= sync2;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/power_ctrl.sv
// Vehicle power-state controller: hold-to-start, immediate stop, stall handling.
// Optional inactivity auto-off is enabled by defining POWER_IDLE_OFF_EN.
module power_ctrl
   import power_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int IDLE_CYCLES     = DEF_IDLE_CYCLES
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       power_on,
   input  logic       power_off,
   input  logic       stall,
   input  logic       activity,
   output logic       power,
   output logic       power_light,
   output logic       on_pulse,
   output logic       off_pulse,
   output logic [1:0] pstate
);

   localparam int HW = cnt_width(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   pstate_t       state;
   logic [HW-1:0] hold_cnt;
   logic          power_q;
   logic          on_db;
   logic          off_db;
   logic          idle_hit;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_on_db (
      .sys_clk (sys_clk),
      .rst     (rst),
      .raw     (power_on),
      .level   (on_db)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_off_db (
      .sys_clk (sys_clk),
      .rst     (rst),
      .raw     (power_off),
      .level   (off_db)
   );

`ifdef POWER_IDLE_OFF_EN
   localparam int IW = cnt_width(IDLE_CYCLES);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

   logic [IW-1:0] idle_cnt;

   // Counts consecutive ON cycles without movement; leaving ON always clears it.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if ((state != ON) || activity) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   assign idle_hit = (state == ON) && (idle_cnt == IDLE_LAST);
`else
   logic unused_idle;

   assign unused_idle = activity ^ (IDLE_CYCLES == 0);
   assign idle_hit    = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state     <= OFF;
         hold_cnt  <= '0;
         power_q   <= 1'b0;
         on_pulse  <= 1'b0;
         off_pulse <= 1'b0;
      end else begin
         on_pulse  <= 1'b0;
         off_pulse <= 1'b0;
         case (state)
            OFF: begin
               hold_cnt <= '0;
               if (on_db && !off_db) begin
                  state <= ARMING;
               end
            end
            ARMING: begin
               if (!on_db || off_db || stall) begin
                  state    <= OFF;
                  hold_cnt <= '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state    <= ON;
                  hold_cnt <= '0;
                  power_q  <= 1'b1;
                  on_pulse <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            ON: begin
               // Off button, stall and idle timeout all share one exit and one strobe.
               if (off_db || stall || idle_hit) begin
                  state     <= RELEASE_WAIT;
                  power_q   <= 1'b0;
                  off_pulse <= 1'b1;
               end
            end
            RELEASE_WAIT: begin
               if (!on_db && !off_db) begin
                  state <= OFF;
               end
            end
            default: begin
               state    <= OFF;
               hold_cnt <= '0;
               power_q  <= 1'b0;
            end
         endcase
      end
   end

   assign power       = power_q;
   assign power_light = power_q;
   assign pstate      = state;

endmodule
